// File: rtl/reg_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_access_ctrl                                               |
// | Purpose  : valid/ready initiator for the single-port register file;      |
// |            optional write read-back check via REG_ACCESS_VERIFY_EN.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module reg_access_ctrl #(
  parameter int WIDTH         = 16,
  parameter int REG_ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [REG_ADDR_BITS-1:0] req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_err,
  output logic                     reg_en,
  output logic                     reg_r_or_w,
  output logic [REG_ADDR_BITS-1:0] reg_addr,
  output logic [WIDTH-1:0]         reg_in,
  input  logic [WIDTH-1:0]         reg_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
`ifdef REG_ACCESS_VERIFY_EN
    ST_VERIFY = 2'd3,
`endif
    ST_RESP   = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     req_ready_q;
  logic                     wr_q;
  logic [REG_ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0]         wdata_q;
  logic                     rsp_valid_q;
  logic                     rsp_write_q;
  logic [WIDTH-1:0]         rsp_rdata_q;
`ifdef REG_ACCESS_VERIFY_EN
  logic                     rsp_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef REG_ACCESS_VERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            wr_q        <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
`ifdef REG_ACCESS_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_write_q <= wr_q;
          if (wr_q) begin
            rsp_rdata_q <= '0;
`ifdef REG_ACCESS_VERIFY_EN
            state_q     <= ST_VERIFY;
`else
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
`endif
          end else begin
            rsp_rdata_q <= reg_out;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
`ifdef REG_ACCESS_VERIFY_EN
        ST_VERIFY: begin
          rsp_rdata_q <= reg_out;
          rsp_err_q   <= (reg_out != wdata_q);
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded from state only, so reset clears the enable without a clock edge.
  assign reg_en     = (state_q == ST_ACCESS)
`ifdef REG_ACCESS_VERIFY_EN
                    || (state_q == ST_VERIFY)
`endif
                    ;
  assign reg_r_or_w = (state_q == ST_ACCESS) && wr_q;
  assign reg_addr   = addr_q;
  assign reg_in     = wdata_q;

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
`ifdef REG_ACCESS_VERIFY_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
`default_nettype wire
